if_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register for the pipelined processor.
- Holds the PC and a loadable instruction memory. Each cycle it fetches one 32-bit instruction and presents it, with its PC, to the decode stage.
- Honours stall requests from hazard detection and branch redirects/flushes from execute.

---
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch + IF/ID pipeline register.
//   Holds the byte-address PC and a loadable instruction memory. Each cycle it
//   reads one word combinationally at pc[AW+1:2] and registers it, together
//   with its PC and PC+4, into IF/ID.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   stall            hold PC and IF/ID
//   flush            replace IF/ID with a bubble (PC still advances)
//   br_taken/target  redirect fetch; wins over stall, inserts a bubble
//   imem_we/waddr/wdata  instruction-memory load port (works in any state)
//   instr, pc_out, pc_plus4, valid   IF/ID contents presented to decode
module if_stage #(
  parameter int          IMEM_DEPTH = 64,
  parameter int          AW         = 6,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP        = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          br_taken,
  input  logic [31:0]   br_target,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   instr,
  output logic [31:0]   pc_out,
  output logic [31:0]   pc_plus4,
  output logic          valid
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] pc_q, pc_d, pc_inc, fetch;
  ifid_t       ifid_q, ifid_d, bubble;

  // Target low bits are discarded to keep the PC word-aligned.
  logic        br_lsb_unused;
  assign br_lsb_unused = ^br_target[1:0];

  // Combinational read; a same-cycle write to this word lands at the edge,
  // so the fetch naturally sees the old contents.
  assign fetch  = imem[pc_q[AW+1:2]];
  assign pc_inc = pc_q + 32'd4;   // wraps modulo 2^32

  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  // Priority: br_taken > stall > flush > normal (rst handled in the register).
  always_comb begin
    bubble.instr    = NOP;
    bubble.pc       = '0;
    bubble.pc_plus4 = '0;
    bubble.valid    = 1'b0;

    pc_d            = pc_inc;
    ifid_d.instr    = fetch;
    ifid_d.pc       = pc_q;
    ifid_d.pc_plus4 = pc_inc;
    ifid_d.valid    = 1'b1;

    if (br_taken) begin
      pc_d   = {br_target[31:2], 2'b00};
      ifid_d = bubble;
    end else if (stall) begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
    end else if (flush) begin
      ifid_d = bubble;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      ifid_q <= bubble;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign instr    = ifid_q.instr;
  assign pc_out   = ifid_q.pc;
  assign pc_plus4 = ifid_q.pc_plus4;
  assign valid    = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush, br_taken, imem_we;
  logic [31:0] br_target, imem_wdata;
  logic [5:0]  imem_waddr;
  logic [31:0] instr, pc_out, pc_plus4;
  logic        valid;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .br_taken(br_taken), .br_target(br_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .instr(instr), .pc_out(pc_out), .pc_plus4(pc_plus4), .valid(valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: memory image, fetch PC, and what decode should see.
  logic [31:0] m_mem [64];
  logic [31:0] m_pc, m_instr, m_pco, m_pc4;
  logic        m_vld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic s, input logic f, input logic b,
                      input logic [31:0] t, input logic we = 1'b0,
                      input logic [5:0] wa = '0, input logic [31:0] wd = '0);
    logic [31:0] fw;
    rst = r; stall = s; flush = f; br_taken = b; br_target = t;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    fw = m_mem[m_pc[7:2]];   // old word, even if written this cycle
    if (r) begin
      m_pc = 32'h0; m_instr = 0; m_pco = 0; m_pc4 = 0; m_vld = 0;
    end else if (b) begin
      m_pc = t & ~32'd3; m_instr = 0; m_pco = 0; m_pc4 = 0; m_vld = 0;
    end else if (s) begin
      // everything holds
    end else if (f) begin
      m_instr = 0; m_pco = 0; m_pc4 = 0; m_vld = 0; m_pc = m_pc + 4;
    end else begin
      m_instr = fw; m_pco = m_pc; m_pc4 = m_pc + 4; m_vld = 1; m_pc = m_pc + 4;
    end
    if (we) m_mem[wa] = wd;
    @(posedge clk);
    #1;
    chk("instr", instr, m_instr);
    chk("pc_out", pc_out, m_pco);
    chk("pc_plus4", pc_plus4, m_pc4);
    chk("valid", {31'b0, valid}, {31'b0, m_vld});
  endtask

  task automatic norm();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    m_pc = 0; m_instr = 0; m_pco = 0; m_pc4 = 0; m_vld = 0;
    // Load the whole memory while held in reset.
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = (i < 4) ? 32'h11 * (i + 1) : (i == 5) ? 32'h55 : $urandom;
      step(1, 0, 0, 0, 0, 1, i[5:0], w);
    end
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);

    // First four fetches after reset.
    norm(); chk("first_instr", instr, 32'h11); chk("first_pc", pc_out, 32'h0);
    norm(); chk("second_instr", instr, 32'h22);
    // Stall three cycles holding 0x22 / pc 4.
    repeat (3) begin
      step(0, 1, 0, 0, 0); chk("stall_hold", instr, 32'h22); chk("stall_pc", pc_out, 32'h4);
    end
    norm(); chk("after_stall", instr, 32'h33); chk("after_stall_pc", pc_out, 32'h8);
    // Misaligned branch target 6 -> fetch resumes at 4.
    step(0, 0, 0, 1, 32'h6); chk("br_bubble", {31'b0, valid}, 32'h0);
    norm(); chk("br_pc", pc_out, 32'h4); chk("br_instr", instr, 32'h22);
    norm();
    // Branch beats stall; stall beats flush.
    step(0, 1, 0, 1, 32'h10); chk("br_over_stall", {31'b0, valid}, 32'h0);
    norm(); chk("br_over_stall_pc", pc_out, 32'h10);
    step(0, 1, 1, 0, 0); chk("stall_over_flush", pc_out, 32'h10);
    step(0, 0, 1, 0, 0);
    norm(); chk("flush_adv", pc_out, 32'h18);
    // Index wrap past word 63.
    step(0, 0, 0, 1, 32'hFC);
    norm(); chk("pc_fc", pc_out, 32'hFC);
    norm(); chk("wrap_pc", pc_out, 32'h100); chk("wrap_instr", instr, 32'h11);
    // 32-bit PC wrap.
    step(0, 0, 0, 1, 32'hFFFF_FFFC);
    norm(); chk("top_pc4", pc_plus4, 32'h0);
    norm(); chk("pc_wrap0", pc_out, 32'h0);
    // Same-cycle write to fetched word: old word first, new word on refetch.
    step(0, 0, 0, 1, 32'h14);
    step(0, 0, 0, 0, 0, 1, 6'd5, 32'hAA); chk("coll_old", instr, 32'h55);
    step(0, 0, 0, 1, 32'h14);
    norm(); chk("coll_new", instr, 32'hAA);
    // Reset during stall and during branch.
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0); chk("rst_in_stall", {31'b0, valid}, 32'h0);
    step(1, 0, 0, 1, 32'h40);
    norm(); chk("rst_over_br", pc_out, 32'h0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic r, s, f, b, we;
      logic [31:0] t;
      r  = ($urandom_range(0, 39) == 0);
      b  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 7) == 0);
      we = ($urandom_range(0, 3) == 0);
      t  = ($urandom_range(0, 3) == 0) ? $urandom : {24'h0, 8'($urandom)};
      step(r, s, f, b, t, we, 6'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
